// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage registers.
package pipe_pkg;

    localparam int PIPE_MAX_DEPTH = 8;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] rd;
    } memWbCtrl_t;

    localparam int CTRL_W_MEMWB = $bits(memWbCtrl_t);

    function automatic int occWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid bit plus control and data payloads.
// An invalid load clears ctrl to CTRL_RST so no stale control is ever presented.
module pipe_slot #(
    parameter int                DATA_W   = 64,
    parameter int                CTRL_W   = 8,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic              srcValid,
    input  logic [CTRL_W-1:0] srcCtrl,
    input  logic [DATA_W-1:0] srcData,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // NOTE: state uses non-blocking assignments so every slot samples its source before any slot updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= CTRL_RST;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            ctrl  <= CTRL_RST;
        end else if (load) begin
            valid <= srcValid;
            if (srcValid) begin
                ctrl <= srcCtrl;
                data <= srcData;
            end else begin
                ctrl <= CTRL_RST;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Multi-slot valid/ready pipeline register with bubble collapse, flush and occupancy.
// Optional stall/bubble performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                CTRL_W   = 8,
    parameter int                DEPTH    = 1,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         flush,
`ifdef PIPE_STAGE_PERF_EN
    output logic [31:0]                  perf_stall_cnt,
    output logic [31:0]                  perf_bubble_cnt,
`endif
    output logic [occWidth(DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = occWidth(DEPTH);

    if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : gBadDepth
        $error("pipe_stage_reg: DEPTH must be in 1..%0d", PIPE_MAX_DEPTH);
    end

    logic [DEPTH-1:0]  v;
    logic [DEPTH-1:0]  adv;
    logic [CTRL_W-1:0] ctrlQ [DEPTH];
    logic [DATA_W-1:0] dataQ [DEPTH];

    // adv[k] = !v[k] | adv[k+1] unrolls to "some slot k..DEPTH-1 is empty, or out_ready".
    always_comb begin
        logic suffixFull;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        adv        = '0;
        suffixFull = 1'b1;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            suffixFull = suffixFull & v[k];
            adv[k]     = out_ready | ~suffixFull;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : gSlot
        logic              srcValid;
        logic [CTRL_W-1:0] srcCtrl;
        logic [DATA_W-1:0] srcData;

        if (k == 0) begin : gHead
            assign srcValid = in_valid;
            assign srcCtrl  = in_ctrl;
            assign srcData  = in_data;
        end else begin : gBody
            assign srcValid = v[k-1];
            assign srcCtrl  = ctrlQ[k-1];
            assign srcData  = dataQ[k-1];
        end

        pipe_slot #(
            .DATA_W   (DATA_W),
            .CTRL_W   (CTRL_W),
            .CTRL_RST (CTRL_RST)
        ) uSlot (
            .clk      (clk),
            .rst      (rst),
            .load     (adv[k]),
            .flush    (flush),
            .srcValid (srcValid),
            .srcCtrl  (srcCtrl),
            .srcData  (srcData),
            .valid    (v[k]),
            .ctrl     (ctrlQ[k]),
            .data     (dataQ[k])
        );
    end

    assign in_ready  = adv[0];
    assign out_valid = v[DEPTH-1];
    assign out_ctrl  = ctrlQ[DEPTH-1];
    assign out_data  = dataQ[DEPTH-1];

    always_comb begin
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt = cnt + OCC_W'(v[k]);
        end
        occupancy = cnt;
    end

`ifdef PIPE_STAGE_PERF_EN
    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && perf_stall_cnt != 32'hFFFF_FFFF) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (!out_valid && perf_bubble_cnt != 32'hFFFF_FFFF) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
